txc_acc_core: RTL and testbench

- Parametrised successor to the TXC-style protection/banking mapper core.
- Holds an ACC_W-bit accumulator, staging register, invert and increment mode flags, latched PRG and CHR bank registers, and an optional mirroring bit.
- Sits between the CPU bus decode and the PRG/CHR address generators of a mapper top.
- Generalises accumulator width, bit position, and bank widths; adds optional software mirroring control and an accumulator readback mask.

---
 rtl/txc_acc_if.sv | 28 ++
 rtl/txc_acc_core.sv | 118 +++++++++++
 tb/tb_txc_acc_core.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/txc_acc_if.sv
// CPU-side bus bundle for txc_acc_core: decode inputs, bank outputs, readback and save-state access.
interface txc_acc_if #(
  parameter int PRG_W = 2,
  parameter int CHR_W = 4
);
  logic [15:0]      cpu_addr;
  logic [7:0]       cpu_dat;
  logic             cpu_rw;
  logic [PRG_W-1:0] prg_bank;
  logic [CHR_W-1:0] chr_bank;
  logic             mir_v;
  logic             reg_oe;
  logic [7:0]       reg_dout;
  logic             ss_act;
  logic             ss_we;
  logic [7:0]       ss_addr;
  logic [7:0]       ss_rdat;

  modport master (
    output cpu_addr, cpu_dat, cpu_rw, ss_act, ss_we, ss_addr,
    input  prg_bank, chr_bank, mir_v, reg_oe, reg_dout, ss_rdat
  );

  modport slave (
    input  cpu_addr, cpu_dat, cpu_rw, ss_act, ss_we, ss_addr,
    output prg_bank, chr_bank, mir_v, reg_oe, reg_dout, ss_rdat
  );
endinterface

// File: rtl/txc_acc_core.sv
// TXC-style accumulator/banking mapper core, all state clocked on the falling edge of m2.
// Optional save-state port is compiled in with the macro TXC_SS_EN.
module txc_acc_core #(
  parameter int ACC_W    = 2,
  parameter int ACC_POS  = 4,
  parameter int PRG_W    = 2,
  parameter int CHR_W    = 4,
  parameter int MIR_CTRL = 0
) (
  input logic     m2,
  input logic     map_rst_n,
  txc_acc_if.slave bus
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_stage;
  logic             r_inv;
  logic             r_inc;
  logic             r_mir;
  logic [PRG_W-1:0] r_prg;
  logic [CHR_W-1:0] r_chr;

  logic       w_wr;
  logic       w_hit_acc;
  logic       w_hit_inv;
  logic       w_hit_stage;
  logic       w_hit_mode;
  logic       w_hit_chr;
  logic       w_hit_prg;
  logic       w_mir;
  logic [7:0] w_dout;

  assign w_wr        = ~bus.cpu_rw;
  assign w_hit_acc   = w_wr && ((bus.cpu_addr & 16'hE103) == 16'h4100);
  assign w_hit_inv   = w_wr && ((bus.cpu_addr & 16'hE103) == 16'h4101);
  assign w_hit_stage = w_wr && ((bus.cpu_addr & 16'hE103) == 16'h4102);
  assign w_hit_mode  = w_wr && ((bus.cpu_addr & 16'hE103) == 16'h4103);
  assign w_hit_chr   = w_wr && ((bus.cpu_addr & 16'hE200) == 16'h4200);
  assign w_hit_prg   = w_wr && bus.cpu_addr[15];
  assign w_mir       = (MIR_CTRL != 0) ? r_mir : 1'b0;

  // Every decode is evaluated against pre-edge state, so mode changes only affect later $4100 writes
  always_ff @(negedge m2) begin
`ifdef TXC_SS_EN
    if (bus.ss_act) begin
      if (bus.ss_we) begin
        case (bus.ss_addr)
          8'd0: r_chr <= bus.cpu_dat[CHR_W-1:0];
          8'd1: r_prg <= bus.cpu_dat[PRG_W-1:0];
          8'd2: begin
            r_mir   <= (MIR_CTRL != 0) ? bus.cpu_dat[7] : 1'b0;
            r_inc   <= bus.cpu_dat[6];
            r_inv   <= bus.cpu_dat[5];
            r_stage <= bus.cpu_dat[ACC_W-1:0];
          end
          8'd3: r_acc <= bus.cpu_dat[ACC_W-1:0];
          default: ;
        endcase
      end
    end else
`endif
    if (!map_rst_n) begin
      r_acc   <= '0;
      r_stage <= '0;
      r_inv   <= 1'b0;
      r_inc   <= 1'b0;
      r_mir   <= 1'b0;
      r_prg   <= '0;
      r_chr   <= '0;
    end else begin
      if (w_hit_acc) begin
        if (r_inc)
          r_acc <= r_acc + ACC_W'(1);
        else
          r_acc <= r_inv ? ~r_stage : r_stage;
      end
      if (w_hit_inv)
        r_inv <= bus.cpu_dat[4];
      if (w_hit_stage)
        r_stage <= bus.cpu_dat[ACC_POS +: ACC_W];
      if (w_hit_mode) begin
        r_inc <= bus.cpu_dat[4];
        r_mir <= (MIR_CTRL != 0) ? bus.cpu_dat[0] : 1'b0;
      end
      if (w_hit_chr)
        r_chr <= bus.cpu_dat[CHR_W-1:0];
      if (w_hit_prg)
        r_prg <= r_acc[PRG_W-1:0];
    end
  end

  // Undriven data bus bits approximate open bus from the high address byte
  always_comb begin
    w_dout = {bus.cpu_addr[15:14], 2'b00, bus.cpu_addr[11:8]};
    w_dout[ACC_POS +: ACC_W] = r_acc;
  end

  assign bus.reg_oe   = bus.cpu_rw && ((bus.cpu_addr & 16'hE100) == 16'h4100);
  assign bus.reg_dout = w_dout;
  assign bus.prg_bank = r_prg;
  assign bus.chr_bank = r_chr;
  assign bus.mir_v    = w_mir;

`ifdef TXC_SS_EN
  always_comb begin
    case (bus.ss_addr)
      8'd0:    bus.ss_rdat = 8'(r_chr);
      8'd1:    bus.ss_rdat = 8'(r_prg);
      8'd2:    bus.ss_rdat = {w_mir, r_inc, r_inv, 1'b0, 4'(r_stage)};
      8'd3:    bus.ss_rdat = 8'(r_acc);
      default: bus.ss_rdat = 8'hFF;
    endcase
  end
`else
  assign bus.ss_rdat = 8'hFF;
`endif

endmodule

// File: tb/tb_txc_acc_core.sv
// Self-checking bench for txc_acc_core: directed scenarios followed by random bus traffic
// compared against an arithmetic model of the mapper registers.
module tb_txc_acc_core;
  localparam int ACC_W    = 2;
  localparam int ACC_POS  = 4;
  localparam int PRG_W    = 2;
  localparam int CHR_W    = 4;
  localparam int MIR_CTRL = 1;
  localparam int ACC_MOD  = 1 << ACC_W;
  localparam int PRG_MOD  = 1 << PRG_W;
  localparam int CHR_MOD  = 1 << CHR_W;

  logic m2;
  logic mapRstN;
  int   errCount;
  int   checkCount;

  int mAcc, mStage, mInv, mInc, mMir, mPrg, mChr;

  txc_acc_if #(.PRG_W(PRG_W), .CHR_W(CHR_W)) bus ();

  txc_acc_core #(
    .ACC_W(ACC_W), .ACC_POS(ACC_POS), .PRG_W(PRG_W), .CHR_W(CHR_W), .MIR_CTRL(MIR_CTRL)
  ) dut (
    .m2(m2),
    .map_rst_n(mapRstN),
    .bus(bus)
  );

  initial m2 = 1'b1;
  always #5 m2 = ~m2;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int expDout(input logic [15:0] addr);
    int d;
    d = (int'(addr[15]) * 128) + (int'(addr[14]) * 64) + int'(addr[11:8]);
    d = d & ~((ACC_MOD - 1) << ACC_POS);
    return d | (mAcc << ACC_POS);
  endfunction

  function automatic int expSs(input logic [7:0] idx);
`ifdef TXC_SS_EN
    case (idx)
      8'd0: return mChr;
      8'd1: return mPrg;
      8'd2: return mMir * 128 + mInc * 64 + mInv * 32 + mStage;
      8'd3: return mAcc;
      default: return 255;
    endcase
`else
    return (idx == idx) ? 255 : 0;
`endif
  endfunction

  function automatic bit ssCompiled();
`ifdef TXC_SS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic modelStep(input logic rstN, input logic [15:0] addr, input int dat,
                           input logic rw, input logic ssAct, input logic ssWe, input int ssAddr);
    int oldAcc;
    if (ssCompiled() && ssAct) begin
      if (ssWe) begin
        if (ssAddr == 0) mChr = dat % CHR_MOD;
        else if (ssAddr == 1) mPrg = dat % PRG_MOD;
        else if (ssAddr == 2) begin
          mMir   = MIR_CTRL ? (dat >> 7) & 1 : 0;
          mInc   = (dat >> 6) & 1;
          mInv   = (dat >> 5) & 1;
          mStage = dat % ACC_MOD;
        end else if (ssAddr == 3) mAcc = dat % ACC_MOD;
      end
    end else if (!rstN) begin
      mAcc = 0; mStage = 0; mInv = 0; mInc = 0; mMir = 0; mPrg = 0; mChr = 0;
    end else if (!rw) begin
      oldAcc = mAcc;
      case (addr & 16'hE103)
        16'h4100: mAcc = mInc ? (mAcc + 1) % ACC_MOD : (mInv ? ACC_MOD - 1 - mStage : mStage);
        16'h4101: mInv = (dat >> 4) & 1;
        16'h4102: mStage = (dat >> ACC_POS) % ACC_MOD;
        16'h4103: begin
          mInc = (dat >> 4) & 1;
          if (MIR_CTRL) mMir = dat & 1;
        end
        default: ;
      endcase
      if ((addr & 16'hE200) == 16'h4200) mChr = dat % CHR_MOD;
      if (addr >= 16'h8000) mPrg = oldAcc % PRG_MOD;
    end
  endtask

  // One m2 cycle: drive on the rising edge, check readback, let the falling edge update, check banks
  task automatic applyStimulus(input logic rstN, input logic [15:0] addr, input logic [7:0] dat,
                               input logic rw, input logic ssAct, input logic ssWe,
                               input logic [7:0] ssAddr);
    @(posedge m2);
    mapRstN      = rstN;
    bus.cpu_addr = addr;
    bus.cpu_dat  = dat;
    bus.cpu_rw   = rw;
    bus.ss_act   = ssAct;
    bus.ss_we    = ssWe;
    bus.ss_addr  = ssAddr;
    #1;
    checkOutput("reg_oe", 16'(bus.reg_oe),
                16'(rw && ((addr & 16'hE100) == 16'h4100)));
    checkOutput("reg_dout", 16'(bus.reg_dout), 16'(expDout(addr)));
    checkOutput("ss_rdat", 16'(bus.ss_rdat), 16'(expSs(ssAddr)));
    @(negedge m2);
    modelStep(rstN, addr, int'(dat), rw, ssAct, ssWe, int'(ssAddr));
    #1;
    checkOutput("prg_bank", 16'(bus.prg_bank), 16'(mPrg));
    checkOutput("chr_bank", 16'(bus.chr_bank), 16'(mChr));
    checkOutput("mir_v", 16'(bus.mir_v), 16'(mMir));
    checkOutput("reg_dout_post", 16'(bus.reg_dout), 16'(expDout(addr)));
  endtask

  task automatic cpuWrite(input logic [15:0] addr, input logic [7:0] dat);
    applyStimulus(1'b1, addr, dat, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic cpuRead(input logic [15:0] addr);
    applyStimulus(1'b1, addr, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  logic [15:0] addrPool [8];
  int accSeq [5];

  initial begin
    errCount = 0; checkCount = 0;
    mAcc = 0; mStage = 0; mInv = 0; mInc = 0; mMir = 0; mPrg = 0; mChr = 0;
    addrPool = '{16'h4100, 16'h4101, 16'h4102, 16'h4103, 16'h4200, 16'h8000, 16'h4300, 16'hC55A};
    accSeq = '{1, 2, 3, 0, 1};

    mapRstN = 1'b0;
    bus.cpu_addr = 16'h0000; bus.cpu_dat = 8'h00; bus.cpu_rw = 1'b1;
    bus.ss_act = 1'b0; bus.ss_we = 1'b0; bus.ss_addr = 8'd0;
    @(negedge m2);
    @(negedge m2);

    $display("[TB] reset state");
    applyStimulus(1'b0, 16'h4100, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("rst_prg", 16'(bus.prg_bank), 16'h0);
    checkOutput("rst_chr", 16'(bus.chr_bank), 16'h0);
    checkOutput("rst_mir", 16'(bus.mir_v), 16'h0);
    checkOutput("rst_oe", 16'(bus.reg_oe), 16'h1);
    checkOutput("rst_dout", 16'(bus.reg_dout), 16'h41);

    $display("[TB] load via stage");
    cpuWrite(16'h4102, 8'h30);
    cpuWrite(16'h4100, 8'h00);
    cpuWrite(16'h8000, 8'h00);
    checkOutput("load_prg", 16'(bus.prg_bank), 16'h3);
    cpuRead(16'h4100);
    checkOutput("load_dout", 16'(bus.reg_dout), 16'h71);

    $display("[TB] invert mode");
    cpuWrite(16'h4101, 8'h10);
    cpuWrite(16'h4102, 8'h10);
    cpuWrite(16'h4100, 8'h00);
    checkOutput("inv_acc", 16'((bus.reg_dout >> ACC_POS) & 8'h3), 16'h2);
    cpuWrite(16'h8000, 8'h00);
    checkOutput("inv_prg", 16'(bus.prg_bank), 16'h2);

    $display("[TB] increment wrap");
    applyStimulus(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0);
    cpuWrite(16'h4103, 8'h10);
    for (int i = 0; i < 5; i++) begin
      cpuWrite(16'h4100, 8'h00);
      checkOutput("inc_acc", 16'((bus.reg_dout >> ACC_POS) & 8'h3), 16'(accSeq[i]));
    end

    $display("[TB] mirroring");
    cpuWrite(16'h4103, 8'h01);
    checkOutput("mir_set", 16'(bus.mir_v), 16'h1);

    $display("[TB] reset priority");
    applyStimulus(1'b0, 16'h4200, 8'h0F, 1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("rstpri_chr0", 16'(bus.chr_bank), 16'h0);
    cpuWrite(16'h4200, 8'h0F);
    checkOutput("rstpri_chr1", 16'(bus.chr_bank), 16'hF);

    $display("[TB] save-state port");
`ifdef TXC_SS_EN
    applyStimulus(1'b1, 16'h4200, 8'h05, 1'b0, 1'b1, 1'b1, 8'd0);
    checkOutput("ss_chr", 16'(bus.chr_bank), 16'h5);
    applyStimulus(1'b1, 16'h4200, 8'h0A, 1'b0, 1'b1, 1'b1, 8'd1);
    checkOutput("ss_block_chr", 16'(bus.chr_bank), 16'h5);
    checkOutput("ss_prg", 16'(bus.prg_bank), 16'h2);
    applyStimulus(1'b0, 16'h4200, 8'h0A, 1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("ss_block_rst", 16'(bus.chr_bank), 16'h5);
`else
    applyStimulus(1'b1, 16'h4200, 8'h0A, 1'b0, 1'b1, 1'b1, 8'd0);
    checkOutput("ss_off_rdat", 16'(bus.ss_rdat), 16'hFF);
    checkOutput("ss_off_chr", 16'(bus.chr_bank), 16'hA);
`endif

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : addrPool[$urandom_range(0, 7)];
      applyStimulus(($urandom_range(0, 19) != 0), a, 8'($urandom),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
                    1'($urandom), 8'($urandom_range(0, 4)));
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end
endmodule
